cordic_share_arb: RTL and testbench

CORDIC_SHARE_ARB -- requirements
Module: cordic_share_arb

---
 rtl/cordic_share_arb_pkg.sv | 15 +
 rtl/cordic_share_arb_rr_pick.sv | 28 ++
 rtl/cordic_share_arb.sv | 159 +++++++++++++++
 tb/tb_cordic_share_arb.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/cordic_share_arb_pkg.sv
// Shared constants and FSM encoding for the shared CORDIC sine-core arbiter.
package cordic_share_arb_pkg;

    localparam int unsigned CORDIC_N_REQ   = 4;
    localparam int unsigned CORDIC_W       = 16;
    localparam int unsigned CORDIC_TIMEOUT = 64;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RETURN = 2'd3
    } arb_state_e;

endpackage : cordic_share_arb_pkg

// File: rtl/cordic_share_arb_rr_pick.sv
// Round-robin picker: one-hot grant for the first requester after ptr_i.
module rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned PW    = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [PW-1:0]    ptr_i,
    output logic [N_REQ-1:0] grant_o
);

    logic [PW-1:0] idx;
    logic          found;

    // Scan ptr+1, ptr+2, ... ptr (wrapping); first active request wins.
    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = '0;
        for (int i = 1; i <= int'(N_REQ); i++) begin
            idx = PW'((int'(ptr_i) + i) % int'(N_REQ));
            if (!found && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

endmodule : rr_pick

// File: rtl/cordic_share_arb.sv
// Arbitrates N_REQ requesters onto one shared sine core, one transaction at a time.
module cordic_share_arb
    import cordic_share_arb_pkg::*;
#(
    parameter int unsigned N_REQ   = CORDIC_N_REQ,
    parameter int unsigned W       = CORDIC_W,
    parameter int unsigned TIMEOUT = CORDIC_TIMEOUT
) (
    input  logic               Clk_i,
    input  logic               Rst_i,
    input  logic [N_REQ-1:0]   Req_i,
    input  logic [N_REQ*W-1:0] Angle_i,
    output logic [N_REQ-1:0]   Ack_o,
    output logic [W-1:0]       Res_o,
    output logic [N_REQ-1:0]   ResVal_o,
    output logic               Err_o,
    output logic [W-1:0]       CoreAngle_o,
    output logic               CoreVal_o,
    input  logic [W-1:0]       CoreSine_i,
    input  logic               CoreDone_i
);

    localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    arb_state_e       state_q, state_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [PW-1:0]    win_q, win_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]    cnt_inc;
    logic             terr_q, terr_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic [N_REQ-1:0] resval_q, resval_d;
    logic             err_q, err_d;
    logic             coreval_q, coreval_d;
    logic [W-1:0]     angle_q, angle_d;
    logic [W-1:0]     res_q, res_d;
    logic [N_REQ-1:0] grant;
    logic [PW-1:0]    grant_idx;
    logic             timeout_hit;

    rr_pick #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_rr_pick (
        .req_i   (Req_i),
        .ptr_i   (ptr_q),
        .grant_o (grant)
    );

    // One-hot grant to binary index.
    always_comb begin
        grant_idx = '0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            if (grant[k]) grant_idx = PW'(k);
        end
    end

    assign cnt_inc     = cnt_q + CW'(1);
    assign timeout_hit = (cnt_inc == CW'(TIMEOUT - 1));

    // State register.
    always_ff @(posedge Clk_i) begin
        if (Rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (|Req_i) state_d = ST_ISSUE;
            ST_ISSUE:  state_d = ST_WAIT;
            ST_WAIT:   if (CoreDone_i || timeout_hit) state_d = ST_RETURN;
            ST_RETURN: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next values; everything lands in registers.
    always_comb begin
        ack_d     = '0;
        coreval_d = 1'b0;
        resval_d  = '0;
        err_d     = 1'b0;
        angle_d   = angle_q;
        res_d     = res_q;
        ptr_d     = ptr_q;
        win_d     = win_q;
        cnt_d     = cnt_q;
        terr_d    = terr_q;
        case (state_q)
            ST_IDLE: begin
                if (|Req_i) begin
                    ack_d   = grant;
                    win_d   = grant_idx;
                    angle_d = Angle_i[int'(grant_idx)*W +: W];
                end
            end
            ST_ISSUE: begin
                coreval_d = 1'b1;
                cnt_d     = '0;
            end
            ST_WAIT: begin
                if (CoreDone_i) begin
                    res_d  = CoreSine_i;
                    terr_d = 1'b0;
                end else begin
                    cnt_d = cnt_inc;
                    if (timeout_hit) begin
                        res_d  = '0;
                        terr_d = 1'b1;
                    end
                end
            end
            ST_RETURN: begin
                resval_d[win_q] = 1'b1;
                err_d           = terr_q;
                ptr_d           = win_q;
            end
            default: ;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge Clk_i) begin
        if (Rst_i) begin
            ptr_q     <= PW'(N_REQ - 1);
            win_q     <= '0;
            cnt_q     <= '0;
            terr_q    <= 1'b0;
            ack_q     <= '0;
            resval_q  <= '0;
            err_q     <= 1'b0;
            coreval_q <= 1'b0;
            angle_q   <= '0;
            res_q     <= '0;
        end else begin
            ptr_q     <= ptr_d;
            win_q     <= win_d;
            cnt_q     <= cnt_d;
            terr_q    <= terr_d;
            ack_q     <= ack_d;
            resval_q  <= resval_d;
            err_q     <= err_d;
            coreval_q <= coreval_d;
            angle_q   <= angle_d;
            res_q     <= res_d;
        end
    end

    assign Ack_o       = ack_q;
    assign ResVal_o    = resval_q;
    assign Err_o       = err_q;
    assign CoreVal_o   = coreval_q;
    assign CoreAngle_o = angle_q;
    assign Res_o       = res_q;

endmodule : cordic_share_arb

// File: tb/tb_cordic_share_arb.sv
// Directed bench for cordic_share_arb; the bench plays the role of the sine core.
module tb_cordic_share_arb;

    logic        Clk_i;
    logic        Rst_i;
    logic [3:0]  Req_i;
    logic [63:0] Angle_i;
    logic [3:0]  Ack_o;
    logic [15:0] Res_o;
    logic [3:0]  ResVal_o;
    logic        Err_o;
    logic [15:0] CoreAngle_o;
    logic        CoreVal_o;
    logic [15:0] CoreSine_i;
    logic        CoreDone_i;

    int checks = 0;
    int errors = 0;
    int ncyc;

    cordic_share_arb #(
        .N_REQ   (4),
        .W       (16),
        .TIMEOUT (64)
    ) dut (
        .Clk_i       (Clk_i),
        .Rst_i       (Rst_i),
        .Req_i       (Req_i),
        .Angle_i     (Angle_i),
        .Ack_o       (Ack_o),
        .Res_o       (Res_o),
        .ResVal_o    (ResVal_o),
        .Err_o       (Err_o),
        .CoreAngle_o (CoreAngle_o),
        .CoreVal_o   (CoreVal_o),
        .CoreSine_i  (CoreSine_i),
        .CoreDone_i  (CoreDone_i)
    );

    initial Clk_i = 1'b0;
    always #5 Clk_i = ~Clk_i;

    task automatic tick();
        @(posedge Clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outs(input string tag);
        check({tag, "_ack"},    32'(Ack_o),       32'h0);
        check({tag, "_resval"}, 32'(ResVal_o),    32'h0);
        check({tag, "_err"},    32'(Err_o),       32'h0);
        check({tag, "_coreval"},32'(CoreVal_o),   32'h0);
        check({tag, "_angle"},  32'(CoreAngle_o), 32'h0);
        check({tag, "_res"},    32'(Res_o),       32'h0);
    endtask

    // One full transaction: request, ack, core start, done after lat WAIT cycles, result.
    task automatic do_txn(input string tag, input logic [3:0] req, input logic [3:0] req_hold,
                          input logic [3:0] exp_oh, input logic [15:0] exp_ang,
                          input int lat, input logic [15:0] sine);
        Req_i = req;
        tick();
        check({tag, "_ack"}, 32'(Ack_o), 32'(exp_oh));
        check({tag, "_coreval_early"}, 32'(CoreVal_o), 32'h0);
        Req_i = req_hold;
        tick();
        check({tag, "_coreval"}, 32'(CoreVal_o), 32'h1);
        check({tag, "_coreangle"}, 32'(CoreAngle_o), 32'(exp_ang));
        repeat (lat) tick();
        check({tag, "_angle_stable"}, 32'(CoreAngle_o), 32'(exp_ang));
        CoreDone_i = 1'b1;
        CoreSine_i = sine;
        tick();
        CoreDone_i = 1'b0;
        check({tag, "_resval_early"}, 32'(ResVal_o), 32'h0);
        tick();
        check({tag, "_resval"}, 32'(ResVal_o), 32'(exp_oh));
        check({tag, "_res"}, 32'(Res_o), 32'(sine));
        check({tag, "_err"}, 32'(Err_o), 32'h0);
    endtask

    initial begin
        Rst_i      = 1'b1;
        Req_i      = 4'b0000;
        Angle_i    = {16'h0033, 16'h0032, 16'h0031, 16'h0030};
        CoreSine_i = 16'h0000;
        CoreDone_i = 1'b0;
        tick();
        tick();
        check_idle_outs("reset");
        Rst_i = 1'b0;

        // Single request, core done 16 cycles after start.
        do_txn("single", 4'b0001, 4'b0000, 4'b0001, 16'h0030, 15, 16'h1234);
        tick();
        check("single_resval_pulse", 32'(ResVal_o), 32'h0);

        // Fairness from reset with everyone requesting.
        Rst_i = 1'b1;
        tick();
        Rst_i = 1'b0;
        do_txn("fair0", 4'b1111, 4'b1111, 4'b0001, 16'h0030, 2, 16'h1000);
        do_txn("fair1", 4'b1111, 4'b1111, 4'b0010, 16'h0031, 2, 16'h1001);
        do_txn("fair2", 4'b1111, 4'b1111, 4'b0100, 16'h0032, 2, 16'h1002);
        do_txn("fair3", 4'b1111, 4'b1111, 4'b1000, 16'h0033, 2, 16'h1003);
        Req_i = 4'b0000;

        // Timeout: core never answers; result 64 cycles after the start pulse.
        CoreSine_i = 16'hBEEF;
        Req_i = 4'b0100;
        tick();
        check("to_ack", 32'(Ack_o), 32'h4);
        Req_i = 4'b0000;
        tick();
        check("to_coreval", 32'(CoreVal_o), 32'h1);
        ncyc = 0;
        while (ResVal_o == 4'b0000 && ncyc < 200) begin
            tick();
            ncyc++;
        end
        check("to_latency", 32'(ncyc), 32'd64);
        check("to_resval", 32'(ResVal_o), 32'h4);
        check("to_err", 32'(Err_o), 32'h1);
        check("to_res", 32'(Res_o), 32'h0);
        tick();
        check("to_err_pulse", 32'(Err_o), 32'h0);
        do_txn("after_to", 4'b0001, 4'b0000, 4'b0001, 16'h0030, 0, 16'h2222);

        // Spurious done in IDLE and ISSUE, then a real done; a new request lands in RETURN.
        CoreDone_i = 1'b1;
        CoreSine_i = 16'hDEAD;
        tick();
        check("spur_idle_resval", 32'(ResVal_o), 32'h0);
        Req_i = 4'b0010;
        tick();
        check("spur_ack", 32'(Ack_o), 32'h2);
        Req_i = 4'b0000;
        tick();
        check("spur_coreval", 32'(CoreVal_o), 32'h1);
        CoreDone_i = 1'b0;
        tick();
        check("spur_resval_none", 32'(ResVal_o), 32'h0);
        tick();
        check("spur_resval_none2", 32'(ResVal_o), 32'h0);
        CoreDone_i = 1'b1;
        CoreSine_i = 16'h5678;
        tick();
        CoreDone_i = 1'b0;
        Req_i = 4'b0110;
        tick();
        check("spur_resval", 32'(ResVal_o), 32'h2);
        check("spur_res", 32'(Res_o), 32'h5678);
        check("spur_err", 32'(Err_o), 32'h0);
        tick();
        check("simul_ack", 32'(Ack_o), 32'h4);
        Req_i = 4'b0000;
        tick();
        check("simul_angle", 32'(CoreAngle_o), 32'h0032);
        CoreDone_i = 1'b1;
        CoreSine_i = 16'h0777;
        tick();
        CoreDone_i = 1'b0;
        tick();
        check("simul_resval", 32'(ResVal_o), 32'h4);
        check("simul_res", 32'(Res_o), 32'h0777);

        // Reset while WAITing: abort silently, late done ignored, index 0 first.
        Req_i = 4'b1000;
        tick();
        check("rst_ack", 32'(Ack_o), 32'h8);
        Req_i = 4'b0000;
        tick();
        check("rst_coreval", 32'(CoreVal_o), 32'h1);
        tick();
        Rst_i = 1'b1;
        tick();
        Rst_i = 1'b0;
        check_idle_outs("rst_wait");
        CoreDone_i = 1'b1;
        CoreSine_i = 16'h4444;
        tick();
        check("rst_late_resval", 32'(ResVal_o), 32'h0);
        tick();
        check("rst_late_resval2", 32'(ResVal_o), 32'h0);
        CoreDone_i = 1'b0;
        do_txn("rst_first", 4'b1111, 4'b0000, 4'b0001, 16'h0030, 1, 16'h3333);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_cordic_share_arb
